// File: rtl/mem_instr_param_if.sv
// Fetch, loader and control bundle between the nRISC core/boot logic (master)
// and the parametrised instruction memory (slave).
interface mem_instr_param_if #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8
);
  logic [AWIDTH-1:0] PC;
  logic              fetch_en;
  logic [WIDTH-1:0]  instrucao;
  logic              instr_valid;
  logic              addr_fault;
  logic              prog_we;
  logic [AWIDTH-1:0] prog_addr;
  logic [WIDTH-1:0]  prog_data;
  logic              prog_err;
  logic              clear;
  logic              ready;

  modport master (
    output PC, fetch_en, prog_we, prog_addr, prog_data, clear,
    input  instrucao, instr_valid, addr_fault, prog_err, ready
  );

  modport slave (
    input  PC, fetch_en, prog_we, prog_addr, prog_data, clear,
    output instrucao, instr_valid, addr_fault, prog_err, ready
  );
endinterface

// File: rtl/mem_instr_param.sv
// Writable instruction memory mapping DEPTH words at BASE into PC space, with
// registered fetch, run-time loader and a zero-fill clear sequencer.
//
// state    | meaning
// ST_CLEAR | sequencer zero-fills mem[clr_idx], one word per edge; bus ignored
// ST_READY | fetches and loader writes accepted
module mem_instr_param #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 26,
  parameter int BASE   = 128
) (
  input logic              clock,
  input logic              reset_n,
  mem_instr_param_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH-1:0] BASE_A  = AWIDTH'(BASE);
  localparam logic [AWIDTH:0]   DEPTH_A = (AWIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]     LAST    = IW'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state;
  logic [IW-1:0]     clr_idx;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [AWIDTH-1:0] fetch_off;
  logic [AWIDTH-1:0] prog_off;
  logic              fetch_in;
  logic              prog_in;
  logic [IW-1:0]     fetch_idx;
  logic [IW-1:0]     prog_idx;

  // Offset wraps modulo 2^AWIDTH; the PC >= BASE term stops low addresses
  // from aliasing into the window.
  assign fetch_off = bus.PC - BASE_A;
  assign prog_off  = bus.prog_addr - BASE_A;
  assign fetch_in  = (bus.PC >= BASE_A) && ({1'b0, fetch_off} < DEPTH_A);
  assign prog_in   = (bus.prog_addr >= BASE_A) && ({1'b0, prog_off} < DEPTH_A);
  assign fetch_idx = fetch_off[IW-1:0];
  assign prog_idx  = prog_off[IW-1:0];

  assign bus.ready = (state == ST_READY);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_CLEAR;
      clr_idx         <= '0;
      bus.instrucao   <= '0;
      bus.instr_valid <= 1'b0;
      bus.addr_fault  <= 1'b0;
      bus.prog_err    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          bus.instr_valid <= 1'b0;
          bus.addr_fault  <= 1'b0;
          bus.prog_err    <= 1'b0;
          if (clr_idx == LAST) begin
            clr_idx <= '0;
            state   <= ST_READY;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          bus.instr_valid <= bus.fetch_en;
          if (bus.fetch_en) begin
            bus.addr_fault <= !fetch_in;
            // Non-blocking read of mem gives read-first against a same-edge write.
            bus.instrucao  <= fetch_in ? mem[fetch_idx] : '0;
          end else begin
            bus.addr_fault <= 1'b0;
          end
          bus.prog_err <= bus.prog_we && !prog_in;
          if (bus.clear) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
          end
        end
      endcase
    end
  end

  // Single write port shared by the clear sequencer and the loader.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (bus.prog_we && prog_in) begin
      mem[prog_idx] <= bus.prog_data;
    end
  end
endmodule

// File: tb/tb_mem_instr_param.sv
// Directed bench for mem_instr_param: clear timing, fetch/window, loader,
// read-first, prog_err, clear request and async reset mid-clear.
module tb_mem_instr_param;
  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  logic [7:0] model [26];

  mem_instr_param_if #(.WIDTH(8), .AWIDTH(8)) bus ();

  mem_instr_param #(.WIDTH(8), .AWIDTH(8), .DEPTH(26), .BASE(128)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.fetch_en  = 1'b0;
    bus.prog_we   = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      tick();
      n++;
    end
    chk(tag, n, exp_edges);
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] a, input logic [7:0] exp_d,
                       input logic exp_fault);
    bus.fetch_en = 1'b1;
    bus.PC       = a;
    tick();
    chk({tag, "_data"}, bus.instrucao, exp_d);
    chk({tag, "_valid"}, bus.instr_valid, 1'b1);
    chk({tag, "_fault"}, bus.addr_fault, exp_fault);
  endtask

  task automatic readback(input string tag);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 26; i++) begin
      bus.fetch_en = 1'b1;
      bus.PC       = 8'(128 + i);
      tick();
      if (bus.instrucao !== model[i] || bus.addr_fault !== 1'b0 || bus.instr_valid !== 1'b1) begin
        bad = 1'b1;
        $display("FAIL %s idx=%0d got=%0h exp=%0h", tag, i, bus.instrucao, model[i]);
      end
    end
    bus.fetch_en = 1'b0;
    chk(tag, bad, 1'b0);
  endtask

  initial begin
    logic quiet;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 26; i++) model[i] = 8'h00;
    idle();
    bus.PC        = 8'h00;
    bus.prog_addr = 8'h00;
    bus.prog_data = 8'h00;
    reset_n       = 1'b0;
    #12;
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instrucao, 8'h00);
    chk("rst_perr",  bus.prog_err, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_ready("ready_after_reset", 26);

    // Whole window reads zero after the initial clear.
    for (int i = 0; i < 26; i++) fetch("zero_fill", 8'(128 + i), 8'h00, 1'b0);
    bus.fetch_en = 1'b0;
    tick();
    chk("idle_valid", bus.instr_valid, 1'b0);
    chk("idle_fault", bus.addr_fault, 1'b0);

    write(8'h80, 8'hAA);
    chk("wr80_perr", bus.prog_err, 1'b0);
    write(8'h99, 8'hC8);
    model[0]  = 8'hAA;
    model[25] = 8'hC8;
    fetch("f80", 8'h80, 8'hAA, 1'b0);
    fetch("f99", 8'h99, 8'hC8, 1'b0);
    fetch("f9a", 8'h9A, 8'h00, 1'b1);
    fetch("fff", 8'hFF, 8'h00, 1'b1);
    fetch("f00", 8'h00, 8'h00, 1'b1);
    fetch("f7f", 8'h7F, 8'h00, 1'b1);
    bus.fetch_en = 1'b0;
    tick();
    chk("hold_valid", bus.instr_valid, 1'b0);
    chk("hold_fault", bus.addr_fault, 1'b0);

    // Read-first on a same-edge write and fetch to 0x85.
    bus.prog_we   = 1'b1;
    bus.prog_addr = 8'h85;
    bus.prog_data = 8'h5A;
    fetch("raw_old", 8'h85, 8'h00, 1'b0);
    bus.prog_we = 1'b0;
    model[5]    = 8'h5A;
    fetch("raw_new", 8'h85, 8'h5A, 1'b0);

    // Write and fetch to different addresses on one edge.
    bus.prog_we   = 1'b1;
    bus.prog_addr = 8'h90;
    bus.prog_data = 8'h33;
    fetch("dual_rd", 8'h80, 8'hAA, 1'b0);
    bus.prog_we = 1'b0;
    model[16]   = 8'h33;
    fetch("dual_wr", 8'h90, 8'h33, 1'b0);
    bus.fetch_en = 1'b0;

    write(8'h7F, 8'h11);
    chk("perr_7f", bus.prog_err, 1'b1);
    tick();
    chk("perr_7f_end", bus.prog_err, 1'b0);
    write(8'hFF, 8'h22);
    chk("perr_ff", bus.prog_err, 1'b1);
    tick();
    chk("perr_ff_end", bus.prog_err, 1'b0);
    readback("rb_after_perr");

    // Clear request; the fetch on the same edge is still serviced.
    bus.clear = 1'b1;
    fetch("clr_edge", 8'h85, 8'h5A, 1'b0);
    bus.clear = 1'b0;
    chk("clr_ready_low", bus.ready, 1'b0);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 8'h81;
    bus.prog_data = 8'h77;
    bus.fetch_en  = 1'b1;
    bus.PC        = 8'h80;
    quiet = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.ready && n < 100) begin
        tick();
        n++;
        if (bus.instr_valid !== 1'b0 || bus.prog_err !== 1'b0 || bus.addr_fault !== 1'b0)
          quiet = 1'b0;
      end
      chk("clear_len", n, 26);
    end
    idle();
    chk("clear_quiet", quiet, 1'b1);
    chk("clear_hold_instr", bus.instrucao, 8'h5A);
    for (int i = 0; i < 26; i++) model[i] = 8'h00;
    readback("rb_after_clear");

    // Async reset partway through a clear sequence.
    write(8'h80, 8'hAA);
    fetch("pre_rst", 8'h80, 8'hAA, 1'b0);
    bus.fetch_en = 1'b0;
    bus.clear    = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midclr_ready", bus.ready, 1'b0);
    chk("midclr_instr", bus.instrucao, 8'hAA);
    reset_n = 1'b0;
    #1;
    chk("async_instr", bus.instrucao, 8'h00);
    chk("async_ready", bus.ready, 1'b0);
    #2;
    reset_n = 1'b1;
    wait_ready("ready_after_midrst", 26);
    readback("rb_after_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
